// File: rtl/prio_encoder_32to5_pkg.sv
// Shared constants, FSM state type and code-to-mask helper
// for the 32-to-5 registered priority encoder.
package prio_encoder_32to5_pkg;

    localparam int N = 32;
    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot mask selecting the line addressed by a code.
    // Same mapping the 5-to-32 decoder uses.
    function automatic logic [N-1:0] code_mask(
        input logic [W-1:0] c
    );
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << c;
    endfunction

endpackage

// File: rtl/prio_enc32_comb.sv
// Combinational 32-bit highest-set-index finder.
// Produces the index of the top set bit and a nonzero flag.
module prio_enc32_comb
    import prio_encoder_32to5_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         nz
);

    // Scan upward so the highest set bit is the last one kept.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    // Group-select: any bit set.
    always_comb begin
        nz = |vec;
    end

endmodule

// File: rtl/prio_encoder_32to5.sv
// Registered 32-to-5 priority encoder with sticky request
// latching and a valid/ack handshake to the consumer.
module prio_encoder_32to5
    import prio_encoder_32to5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         flush,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         any
);

    state_t       state;
    state_t       state_d;
    logic [W-1:0] code_d;
    logic         valid_d;
    logic [N-1:0] pend_d;
    logic [N-1:0] clr;
    logic [N-1:0] set;
    logic         take;
    logic [W-1:0] enc_idx;
    logic         enc_nz;

    prio_enc32_comb u_enc (
        .vec (pending),
        .idx (enc_idx),
        .nz  (enc_nz)
    );

    // Accepted grant: ack only counts while a code is presented.
    always_comb begin
        take = (state == PRESENT) && ack && valid;
        clr  = take ? code_mask(code) : '0;
        set  = en ? req : '0;
    end

    // Sticky pending update; a same-cycle set re-arms the bit.
    always_comb begin
        pend_d = (pending & ~clr) | set;
        if (flush) begin
            pend_d = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; flush forces a return to IDLE.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (enc_nz) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Output logic: capture code on entry, freeze while presenting.
    always_comb begin
        code_d  = code;
        valid_d = valid;
        unique case (state)
            IDLE: begin
                if (enc_nz) begin
                    code_d  = enc_idx;
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            PRESENT: begin
                if (take) begin
                    valid_d = 1'b0;
                end
            end
            default: valid_d = 1'b0;
        endcase
        if (flush) begin
            code_d  = code;
            valid_d = 1'b0;
        end
    end

    // Output and pending registers; any mirrors pend_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= '0;
            valid   <= 1'b0;
            pending <= '0;
            any     <= 1'b0;
        end else begin
            code    <= code_d;
            valid   <= valid_d;
            pending <= pend_d;
            any     <= |pend_d;
        end
    end

endmodule

// File: tb/tb_prio_encoder_32to5.sv
// Directed self-checking bench for prio_encoder_32to5.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_prio_encoder_32to5;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] req;
    logic        flush;
    logic        ack;
    logic [4:0]  code;
    logic        valid;
    logic [31:0] pending;
    logic        any;

    int vectors;
    int miscompares;

    prio_encoder_32to5 dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .flush   (flush),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .any     (any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en    = 1'b1;
        req   = '0;
        flush = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({code, valid, pending, any} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset: code=%0d valid=%b pend=%h any=%b want all 0",
                     code, valid, pending, any);
        end
        req = 32'h1;
        step();
        req = '0;
        vectors++;
        if (pending !== 32'h1 || valid !== 1'b0 || any !== 1'b1) begin
            miscompares++;
            $display("FAIL single_capture: pend=%h valid=%b any=%b want 1/0/1",
                     pending, valid, any);
        end
        step();
        vectors++;
        if (valid !== 1'b1 || code !== 5'd0) begin
            miscompares++;
            $display("FAIL single_present: valid=%b code=%0d want 1/0",
                     valid, code);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++;
        if (valid !== 1'b0 || pending !== 32'h0 || any !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack: valid=%b pend=%h any=%b want 0/0/0",
                     valid, pending, any);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        req = 32'h8000_0010;
        ack = 1'b1;
        step();
        req = '0;
        step();
        vectors++;
        if (valid !== 1'b1 || code !== 5'd31) begin
            miscompares++;
            $display("FAIL prio_first: valid=%b code=%0d want 1/31",
                     valid, code);
        end
        step();
        vectors++;
        if (valid !== 1'b0 || pending !== 32'h10) begin
            miscompares++;
            $display("FAIL prio_bubble: valid=%b pend=%h want 0/00000010",
                     valid, pending);
        end
        step();
        vectors++;
        if (valid !== 1'b1 || code !== 5'd4) begin
            miscompares++;
            $display("FAIL prio_second: valid=%b code=%0d want 1/4",
                     valid, code);
        end
        step();
        ack = 1'b0;
        vectors++;
        if (pending !== 32'h0 || valid !== 1'b0 || any !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_end: pend=%h valid=%b any=%b want 0/0/0",
                     pending, valid, any);
        end
    endtask

    task automatic test_preempt_rearm();
        idle_inputs();
        req = 32'h4;
        step();
        req = '0;
        step();
        req = 32'h0010_0000;
        step();
        req = '0;
        vectors++;
        if (code !== 5'd2 || valid !== 1'b1 || pending !== 32'h0010_0004) begin
            miscompares++;
            $display("FAIL no_preempt: code=%0d valid=%b pend=%h want 2/1/00100004",
                     code, valid, pending);
        end
        step();
        vectors++;
        if (code !== 5'd2 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_code: code=%0d valid=%b want 2/1", code, valid);
        end
        ack = 1'b1;
        req = 32'h4;
        step();
        ack = 1'b0;
        req = '0;
        vectors++;
        if (pending !== 32'h0010_0004 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm: pend=%h valid=%b want 00100004/0",
                     pending, valid);
        end
        step();
        vectors++;
        if (code !== 5'd20 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL grant20: code=%0d valid=%b want 20/1", code, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++;
        if (pending !== 32'h4) begin
            miscompares++;
            $display("FAIL clear20: pend=%h want 00000004", pending);
        end
        step();
        vectors++;
        if (code !== 5'd2 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL grant2: code=%0d valid=%b want 2/1", code, valid);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++;
        if (pending !== 32'h0 || any !== 1'b0) begin
            miscompares++;
            $display("FAIL clear2: pend=%h any=%b want 0/0", pending, any);
        end
    endtask

    task automatic test_enable_ack();
        logic [31:0] exp;
        idle_inputs();
        en  = 1'b0;
        req = 32'hFFFF_FFFF;
        step();
        vectors++;
        if (pending !== 32'h0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL en_off: pend=%h valid=%b want 0/0", pending, valid);
        end
        req = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++;
        if (pending !== 32'h0 || valid !== 1'b0 || any !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_ack: pend=%h valid=%b any=%b want 0/0/0",
                     pending, valid, any);
        end
        en  = 1'b1;
        req = 32'hFFFF_FFFF;
        step();
        req = '0;
        vectors++;
        if (pending !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL all_capture: pend=%h want ffffffff", pending);
        end
        for (int k = 31; k >= 0; k--) begin
            step();
            vectors++;
            if (valid !== 1'b1 || code !== 5'(k)) begin
                miscompares++;
                $display("FAIL drain_code: valid=%b code=%0d want 1/%0d",
                         valid, code, k);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            exp = (32'h1 << k) - 32'h1;
            vectors++;
            if (pending !== exp || valid !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_clear: pend=%h valid=%b want %h/0",
                         pending, valid, exp);
            end
        end
        vectors++;
        if (any !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_any: any=%b want 0", any);
        end
    endtask

    task automatic test_sweep();
        int hits;
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            hits = 0;
            req = 32'h1 << i;
            step();
            req = '0;
            for (int c = 0; c < 3; c++) begin
                step();
                if (valid === 1'b1 && code === 5'(i)) hits++;
            end
            vectors++;
            if (valid !== 1'b1 || code !== 5'(i)) begin
                miscompares++;
                $display("FAIL sweep_stable: bit %0d valid=%b code=%0d want 1/%0d",
                         i, valid, code, i);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
            vectors++;
            if (valid !== 1'b0 || pending !== 32'h0) begin
                miscompares++;
                $display("FAIL sweep_ack: bit %0d valid=%b pend=%h want 0/0",
                         i, valid, pending);
            end
            step();
            vectors++;
            if (hits !== 3 || valid !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_once: bit %0d hits=%0d valid=%b want 3/0",
                         i, hits, valid);
            end
        end
    endtask

    task automatic test_flush_rst();
        idle_inputs();
        req = 32'h0000_F000;
        step();
        req = '0;
        step();
        vectors++;
        if (code !== 5'd15 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup: code=%0d valid=%b want 15/1", code, valid);
        end
        flush = 1'b1;
        ack   = 1'b1;
        req   = 32'h8;
        step();
        idle_inputs();
        vectors++;
        if (pending !== 32'h0 || valid !== 1'b0 || any !== 1'b0
            || code !== 5'd15) begin
            miscompares++;
            $display("FAIL flush: pend=%h valid=%b any=%b code=%0d want 0/0/0/15",
                     pending, valid, any, code);
        end
        step();
        vectors++;
        if (valid !== 1'b0 || pending !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_idle: valid=%b pend=%h want 0/0", valid, pending);
        end
        req = 32'h0000_F000;
        step();
        req = '0;
        step();
        vectors++;
        if (code !== 5'd15 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: code=%0d valid=%b want 15/1", code, valid);
        end
        rst = 1'b1;
        ack = 1'b1;
        req = 32'h8;
        step();
        rst = 1'b0;
        idle_inputs();
        vectors++;
        if ({code, valid, pending, any} !== 39'd0) begin
            miscompares++;
            $display("FAIL rst_mid: code=%0d valid=%b pend=%h any=%b want all 0",
                     code, valid, pending, any);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_priority();
        test_preempt_rearm();
        test_enable_ack();
        test_sweep();
        test_flush_rst();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
